// File: rtl/dense_layer.sv
// Fully-connected classifier stage: one sequential MAC computes NUM_OUT saturated
// fixed-point logits from the flattened feature vector and reports the argmax class.
module dense_layer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FRAC_W  = 8,
    parameter int unsigned IN_LEN  = 121,
    parameter int unsigned NUM_OUT = 10,
    parameter int unsigned ACC_W   = 40,
    localparam int unsigned WA_W   = $clog2(NUM_OUT * IN_LEN),
    localparam int unsigned N_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    input  logic signed [DATA_W-1:0] flat_in [0:IN_LEN-1],
    output logic        [WA_W-1:0]   w_addr,
    output logic                     w_en,
    input  logic signed [DATA_W-1:0] w_data,
    output logic        [N_W-1:0]    b_addr,
    input  logic signed [DATA_W-1:0] b_data,
    output logic signed [DATA_W-1:0] logits [0:NUM_OUT-1],
    output logic        [N_W-1:0]    class_out
);

    localparam int unsigned I_W = $clog2(IN_LEN + 1);
    localparam int unsigned P_W = 2 * DATA_W;

    localparam logic [I_W-1:0] LAST_I = I_W'(IN_LEN - 1);
    localparam logic [I_W-1:0] DRAIN_I = I_W'(IN_LEN);
    localparam logic [N_W-1:0] LAST_N = N_W'(NUM_OUT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StFin, StDone} state_e;

    state_e                    state_q;
    logic        [I_W-1:0]     i_q;
    logic        [I_W-1:0]     i_d_q;
    logic                      rd_vld_q;
    logic        [N_W-1:0]     n_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  max_q;
    logic        [N_W-1:0]     class_q;

    logic signed [P_W-1:0]     w_ext;
    logic signed [P_W-1:0]     x_ext;
    logic signed [P_W-1:0]     prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sh;
    logic signed [ACC_W-1:0]   b_ext;
    logic signed [ACC_W-1:0]   r;
    logic signed [DATA_W-1:0]  sat;
    logic                      better;

    assign b_addr = n_q;

    always_comb begin
        w_ext    = {{(P_W-DATA_W){w_data[DATA_W-1]}}, w_data};
        x_ext    = {{(P_W-DATA_W){flat_in[i_d_q][DATA_W-1]}}, flat_in[i_d_q]};
        prod     = w_ext * x_ext;
        prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
        acc_sh   = acc_q >>> FRAC_W;
        b_ext    = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data};
        r        = acc_sh + b_ext;
        if (r > SAT_MAX) begin
            sat = OUT_MAX;
        end else if (r < SAT_MIN) begin
            sat = OUT_MIN;
        end else begin
            sat = r[DATA_W-1:0];
        end
        // Strict greater-than keeps the lowest index on ties.
        better = (n_q == '0) || (sat > max_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            i_q       <= '0;
            i_d_q     <= '0;
            rd_vld_q  <= 1'b0;
            n_q       <= '0;
            acc_q     <= '0;
            max_q     <= '0;
            class_q   <= '0;
            class_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            w_en      <= 1'b0;
            w_addr    <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                logits[k] <= '0;
            end
        end else begin
            // ROM data returns one cycle after the read was issued.
            rd_vld_q <= w_en;
            i_d_q    <= i_q;
            done     <= 1'b0;
            if (rd_vld_q) begin
                acc_q <= acc_q + prod_ext;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= '0;
                        n_q     <= '0;
                        i_q     <= '0;
                        w_addr  <= '0;
                        w_en    <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    i_q <= i_q + I_W'(1);
                    if (i_q < LAST_I) begin
                        w_addr <= w_addr + WA_W'(1);
                    end
                    if (i_q == LAST_I) begin
                        w_en <= 1'b0;
                    end
                    if (i_q == DRAIN_I) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    logits[n_q] <= sat;
                    if (better) begin
                        max_q   <= sat;
                        class_q <= n_q;
                    end
                    acc_q <= '0;
                    i_q   <= '0;
                    if (n_q == LAST_N) begin
                        // done is registered so it is high during the DONE state.
                        class_out <= better ? n_q : class_q;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        n_q     <= n_q + N_W'(1);
                        w_addr  <= w_addr + WA_W'(1);
                        w_en    <= 1'b1;
                        state_q <= StMac;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer: ROM models, an arithmetic reference model and a
// per-cycle compare process for handshake, ROM addressing and logit results.
module tb_dense_layer;

    localparam int IN   = 121;
    localparam int NO   = 10;
    localparam int PER  = IN + 2;
    localparam int DCYC = NO * PER + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               done;
    logic               busy;
    logic signed [15:0] flat [0:IN-1];
    logic        [10:0] w_addr;
    logic               w_en;
    logic signed [15:0] w_data;
    logic        [3:0]  b_addr;
    logic signed [15:0] b_data;
    logic signed [15:0] logits [0:NO-1];
    logic        [3:0]  class_out;

    logic signed [15:0] wmem [0:NO*IN-1];
    logic signed [15:0] bmem [0:NO-1];

    longint exp_logits [0:NO-1];
    int     exp_class;
    int     prev_class = 0;
    int     passed = 0;
    int     total = 0;
    int     cyc = 0;
    bit     trk = 1'b0;

    dense_layer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .flat_in   (flat),
        .w_addr    (w_addr),
        .w_en      (w_en),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .logits    (logits),
        .class_out (class_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
        b_data <= bmem[b_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NO * IN; i++) wmem[i] = '0;
        for (int i = 0; i < NO; i++) bmem[i] = '0;
        for (int i = 0; i < IN; i++) flat[i] = '0;
    endtask

    // Reference: plain dot product, floor-divide by 2^8, add bias, clamp, argmax.
    task automatic compute_model();
        longint best;
        exp_class = 0;
        best = 0;
        for (int n = 0; n < NO; n++) begin
            longint s;
            s = 0;
            for (int i = 0; i < IN; i++) s += longint'(wmem[n*IN+i]) * longint'(flat[i]);
            s = (s >>> 8) + longint'(bmem[n]);
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_logits[n] = s;
            if (n == 0 || s > best) begin
                best = s;
                exp_class = n;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (trk) begin
            int c, nidx, k;
            cyc++;
            c = cyc - 1;
            nidx = c / PER;
            k = c % PER;
            if (cyc < DCYC) begin
                check("busy", busy, 1);
                check("done_early", done, 0);
                check("w_en", w_en, (k < IN) ? 1 : 0);
                if (k < IN) check("w_addr", w_addr, nidx * IN + k);
                check("b_addr", b_addr, nidx);
                check("class_hold", class_out, prev_class);
            end else begin
                check("done_pulse", done, 1);
                check("busy_end", busy, 0);
                check("class_out", class_out, exp_class);
                prev_class = exp_class;
                trk = 1'b0;
            end
            if (cyc > 1 && k == 0) check("logit", logits[nidx-1], exp_logits[nidx-1]);
        end
    end

    task automatic launch();
        compute_model();
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        trk = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int t;
        t = 0;
        while (trk && t < DCYC + 50) begin
            @(negedge clk);
            t++;
        end
        if (trk) begin
            check({tag, "_timeout"}, 1, 0);
            trk = 1'b0;
        end
        repeat (2) @(negedge clk);
        check({tag, "_no_second_done"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_w_en"}, w_en, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_class"}, class_out, 0);
        for (int n = 0; n < NO; n++) check({tag, "_logit"}, logits[n], 0);
    endtask

    task automatic setup_n3();
        clear_all();
        for (int i = 0; i < IN; i++) begin
            wmem[3*IN+i] = 16'sd256;
            flat[i] = 16'sd256;
        end
    endtask

    initial begin
        clear_all();
        #23;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Neuron 3 only: 121 * 1.0 * 1.0 = 121.0 -> 30976.
        setup_n3();
        launch();
        finish_run("n3");
        check("n3_lit_logit3", logits[3], 30976);
        check("n3_lit_logit0", logits[0], 0);
        check("n3_lit_class", class_out, 3);

        // Positive and negative saturation on neuron 5.
        clear_all();
        for (int i = 0; i < IN; i++) begin
            wmem[5*IN+i] = 16'sd512;
            flat[i] = 16'sd256;
        end
        launch();
        finish_run("satp");
        check("satp_lit_logit5", logits[5], 32767);
        check("satp_lit_class", class_out, 5);
        for (int i = 0; i < IN; i++) flat[i] = -16'sd256;
        launch();
        finish_run("satn");
        check("satn_lit_logit5", logits[5], -32768);
        check("satn_lit_class", class_out, 0);

        // Floor shift: -1/256 floors to -1, plus bias 10.
        clear_all();
        flat[0] = -16'sd1;
        wmem[0] = 16'sd1;
        bmem[0] = 16'sd10;
        launch();
        finish_run("floor");
        check("floor_lit_logit0", logits[0], 9);

        // Ties resolve to the lowest index.
        clear_all();
        bmem[2] = 16'sd100;
        bmem[7] = 16'sd100;
        launch();
        finish_run("tie");
        check("tie_lit_class", class_out, 2);
        check("tie_lit_logit7", logits[7], 100);
        bmem[2] = '0;
        bmem[7] = '0;
        launch();
        finish_run("zero");
        check("zero_lit_class", class_out, 0);

        // Second start mid-run must be ignored.
        setup_n3();
        launch();
        while (trk && cyc < 500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("restart");
        check("restart_lit_logit3", logits[3], 30976);

        // Asynchronous reset mid-run, then a fresh run.
        setup_n3();
        bmem[1] = 16'sd5;
        launch();
        while (trk && cyc < 700) @(negedge clk);
        trk = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        prev_class = 0;
        repeat (3) @(negedge clk);
        check("midrst_hold_w_en", w_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        launch();
        finish_run("postrst");
        check("postrst_lit_logit3", logits[3], 30976);
        check("postrst_lit_logit1", logits[1], 5);
        check("postrst_lit_class", class_out, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dense_layer.md
Name: dense_layer

Overview:
- Fully-connected classifier stage directly downstream of the flatten stage.
- Consumes the 121-element flattened feature vector and computes NUM_OUT signed fixed-point logits (weights·x + bias), one neuron at a time, with a single sequential MAC.
- Reports the argmax class index.
- Weights and biases come from external synchronous ROMs with 1-cycle read latency.

Parameters:
- DATA_W, 16, width of activations, weights, biases and logits (signed, Q(DATA_W-FRAC_W).FRAC_W).
- FRAC_W, 8, fractional bits shared by activations, weights and biases.
- IN_LEN, 121, length of the input vector.
- NUM_OUT, 10, number of output neurons (digit classes).
- ACC_W, 40, accumulator width; must be ≥ 2*DATA_W + clog2(IN_LEN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- done  output  1  one-cycle pulse when all logits and class_out are valid.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- flat_in  input  signed DATA_W x [0:IN_LEN-1]  feature vector; must stay stable from start until done.
- w_addr  output  clog2(NUM_OUT*IN_LEN)  weight ROM address, row-major: n*IN_LEN + i.
- w_en  output  1  weight ROM read enable.
- w_data  input  signed DATA_W  weight ROM data, valid 1 cycle after w_en/w_addr.
- b_addr  output  clog2(NUM_OUT)  bias ROM address = current neuron index.
- b_data  input  signed DATA_W  bias ROM data, valid 1 cycle after b_addr changes.
- logits  output  signed DATA_W x [0:NUM_OUT-1]  per-neuron results.
- class_out  output  clog2(NUM_OUT)  argmax of logits.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - State returns to IDLE.
  - done, busy, w_en = 0; w_addr, b_addr = 0.
  - All logits = 0; class_out = 0; accumulator and indices = 0.
- States: IDLE, MAC, FIN, DONE.
- IDLE:
  - done = 0.
  - On start: clear acc, neuron n = 0, index i = 0; go to MAC next cycle.
- MAC (IN_LEN+1 cycles per neuron):
  - Cycles 0..IN_LEN-1: w_en = 1, w_addr = n*IN_LEN + i, i increments.
  - From cycle 1 through cycle IN_LEN: acc += w_data * flat_in[i_d], where i_d is i delayed one cycle. The product is full 2*DATA_W, sign-extended to ACC_W.
  - w_en = 0 in the drain cycle (cycle IN_LEN); then go to FIN.
- FIN (1 cycle):
  - r = (acc >>> FRAC_W) + b_data, arithmetic shift (floor toward -inf).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; write the result to logits[n].
  - Argmax update: if n == 0 or sat result > running max, then max = result and class_reg = n. Strict greater-than, so ties resolve to the lowest index.
  - Clear acc and i.
  - If n == NUM_OUT-1, go to DONE; else n++ and go to MAC.
- b_addr = n throughout the neuron, so b_data is settled by FIN.
- DONE:
  - class_out <= class_reg; done <= 1 for exactly one cycle.
  - busy drops in the same cycle done rises; return to IDLE.
- Latency:
  - Start sampled at cycle 0; neuron n occupies cycles 1+n*(IN_LEN+2) .. (n+1)*(IN_LEN+2).
  - done is high at cycle NUM_OUT*(IN_LEN+2)+1, which is cycle 1231 for the defaults.
- start while busy is ignored, with no restart or queuing; start coincident with done is ignored.
- logits[k] update progressively during a run. class_out changes only at done. Both hold until the next run or reset.

Test Plan:
- Neuron 3 weights all 256, others 0; flat_in all 256; biases 0 -> logits[3] = 30976, all others 0; class_out = 3; done exactly at cycle 1231 after start; busy high cycles 1..1230.
- Neuron 5 weights all 512, flat_in all 256 -> logits[5] saturates to 32767. Same weights with flat_in all -256 -> logits[5] = -32768.
- Floor/bias check: flat_in[0] = -1, w[0][0] = 1, all else 0, b[0] = 10 -> logits[0] = 9 ((-1>>>8) = -1).
- Ties: all weights 0; biases b[2] = b[7] = 100, others 0 -> class_out = 2. With all biases 0 -> class_out = 0.
- Start pulsed again at cycle 500 of a run -> ignored; single done at 1231; w_addr sequence uninterrupted (monotonic per neuron).
- rst_n low at cycle 700, released, then a new start -> all outputs 0 during reset, w_en = 0; new run completes with correct logits and done 1231 cycles after its start.
